// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if: D-stage operand/hazard bus between the pipeline and the forwarding unit
interface fwd_scoreboard_if #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int TW     = 2,
    parameter int NSTAGE = 3,
    parameter int NREAD  = 2,
    parameter int CW     = 16,
    parameter int SW     = $clog2(NSTAGE + 1)
);
    logic                d_valid;
    logic [NREAD*AW-1:0] d_rd_addr;
    logic [NREAD*TW-1:0] d_tuse;
    logic                d_wr_en;
    logic [AW-1:0]       d_wr_addr;
    logic [TW-1:0]       d_tnew;
    logic                d_md_use;
    logic                md_busy;
    logic                flush;
    logic [NREAD*DW-1:0] rf_rdata;
    logic [NSTAGE*DW-1:0] stage_data;
    logic                stall;
    logic [NREAD*DW-1:0] fwd_data;
    logic [NREAD*SW-1:0] fwd_sel;
    logic [CW-1:0]       stall_cycles;

    modport master (
        output d_valid, d_rd_addr, d_tuse, d_wr_en, d_wr_addr, d_tnew, d_md_use, md_busy, flush,
               rf_rdata, stage_data,
        input  stall, fwd_data, fwd_sel, stall_cycles
    );

    modport slave (
        input  d_valid, d_rd_addr, d_tuse, d_wr_en, d_wr_addr, d_tnew, d_md_use, md_busy, flush,
               rf_rdata, stage_data,
        output stall, fwd_data, fwd_sel, stall_cycles
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: D-stage hazard detection and operand forwarding from an in-flight writer scoreboard
module fwd_scoreboard #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int TW     = 2,
    parameter int NSTAGE = 3,
    parameter int NREAD  = 2,
    parameter int CW     = 16,
    parameter int SW     = $clog2(NSTAGE + 1)
) (
    input logic             clk,
    input logic             reset,
    fwd_scoreboard_if.slave bus
);
    logic [NSTAGE-1:0]   vld;
    logic [AW-1:0]       addr [NSTAGE];
    logic [TW-1:0]       tnew [NSTAGE];
    logic [NREAD-1:0]    hit;
    logic [NREAD-1:0]    hazard;
    logic [TW-1:0]       hit_tnew [NREAD];
    logic [SW-1:0]       hit_sel [NREAD];
    logic [DW-1:0]       hit_data [NREAD];
    logic [NREAD*DW-1:0] fwd_data;
    logic [NREAD*SW-1:0] fwd_sel;
    logic                stall;
    logic [CW-1:0]       stall_cycles;

    // Per port: scan oldest to youngest so the lowest matching index (youngest writer) wins
    always_comb begin
        hit = '0;
        hazard = '0;
        fwd_data = bus.rf_rdata;
        fwd_sel = '0;
        for (int p = 0; p < NREAD; p++) begin
            hit_tnew[p] = '0;
            hit_sel[p] = '0;
            hit_data[p] = '0;
            for (int i = NSTAGE - 1; i >= 0; i--) begin
                if (vld[i] && (|bus.d_rd_addr[p*AW+:AW]) && addr[i] == bus.d_rd_addr[p*AW+:AW]) begin
                    hit[p] = 1'b1;
                    hit_tnew[p] = tnew[i];
                    hit_sel[p] = SW'(i + 1);
                    hit_data[p] = bus.stage_data[i*DW+:DW];
                end
            end
            if (hit[p] && hit_tnew[p] == '0) begin
                fwd_data[p*DW+:DW] = hit_data[p];
                fwd_sel[p*SW+:SW] = hit_sel[p];
            end
            hazard[p] = hit[p] && (hit_tnew[p] > bus.d_tuse[p*TW+:TW]);
        end
    end

    assign stall = bus.d_valid & ((|hazard) | (bus.d_md_use & bus.md_busy));
    assign bus.stall = stall;
    assign bus.fwd_data = fwd_data;
    assign bus.fwd_sel = fwd_sel;
    assign bus.stall_cycles = stall_cycles;

    // Scoreboard shift: D enters E unless stalled/flushed, older entries age and retire past W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
            for (int i = 0; i < NSTAGE; i++) begin
                addr[i] <= '0;
                tnew[i] <= '0;
            end
        end else begin
            vld[0] <= !stall && !bus.flush && bus.d_valid && bus.d_wr_en && (|bus.d_wr_addr);
            addr[0] <= bus.d_wr_addr;
            tnew[0] <= bus.d_tnew;
            for (int i = 1; i < NSTAGE; i++) begin
                vld[i] <= vld[i-1];
                addr[i] <= addr[i-1];
                tnew[i] <= (tnew[i-1] == '0) ? '0 : tnew[i-1] - 1'b1;
            end
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cycles <= '0;
        else if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
    end
endmodule
